dlbf_slave_rxbuf: RTL and testbench
===================================

// Module: dlbf_slave_rxbuf
// PURPOSE
//  Single-clock, parametrised slave receive buffer for the DLBF slave datapath.
//  - Captures AXI-Stream beats into an internal RAM over NITER tlast-delimited iterations.
//  - Reports done / state / fill count and exposes a BRAM-style port B for readback and host write.
//  - Lives entirely in the s_axis_clk domain; no synchroniser stage is needed around it.
//  - Adds an optional wrap (ring) capture mode with a sticky overflow flag.
// PARAMETERS
//  DATA_WIDTH   64  stream / RAM word width (bits)
//  ADDR_WIDTH   13  RAM address width; DEPTH = 2**ADDR_WIDTH words
//  NITER_WIDTH  12  width of iteration-count input
//  WRAP_MODE    0   0 = stop with error when full; 1 = ring buffer, overwrite oldest
// PORTS
//  s_axis_clk     in   1             sole clock
//  slave_rst      in   1             synchronous, active-high reset
//  start          in   1             one-cycle pulse; arms capture (accepted in IDLE/DONE/ERR only)
//  niter          in   NITER_WIDTH   iterations to capture, sampled on start
//  s_axis_tdata   in   DATA_WIDTH    stream data
//  s_axis_tvalid  in   1             stream valid
//  s_axis_tlast   in   1             last beat of one iteration
//  s_axis_tready  out  1             stream ready
//  addrb          in   ADDR_WIDTH    port-B word address
//  dinb           in   DATA_WIDTH    port-B write data
//  enb            in   1             port-B enable
//  web            in   1             port-B write enable (qualified by enb)
//  doutb          out  DATA_WIDTH    port-B read data
//  rxdone         out  1             capture complete, level
//  current_state  out  4             FSM state code
//  rxram_counter  out  ADDR_WIDTH+1  beats stored, saturating at DEPTH
//  overflow       out  1             sticky: WRAP_MODE=1 wrote past DEPTH
// BEHAVIOUR
//  Reset (slave_rst=1 at a clock edge)
//   - Registered outputs clear: s_axis_tready, doutb, rxdone, overflow, rxram_counter; current_state=IDLE.
//   - Internal wr_addr and iter_cnt clear.
//   - RAM contents are not cleared.
//   - Reset mid-capture aborts immediately; no partial rxdone.
//  FSM encoding: IDLE=4'd0, RECV=4'd1, DONE=4'd2, ERR=4'd3.
//   - IDLE/DONE/ERR, start=1:
//     - niter==0 -> DONE next cycle.
//     - otherwise -> RECV.
//     - Either way: clear wr_addr, iter_cnt, rxram_counter, overflow, rxdone.
//   - RECV, start: ignored.
//   - RECV: tready=1 registered. It rises the cycle after entering RECV and drops the cycle after leaving.
//     - A beat is accepted on tvalid&tready and written to RAM[wr_addr]; wr_addr increments.
//     - rxram_counter increments, saturating at DEPTH.
//     - Accepted beat with tlast: iter_cnt+1; if iter_cnt+1==niter -> DONE.
//     - Accepted beat making the stored count reach DEPTH without finishing the last iteration:
//       - WRAP_MODE=0 -> ERR. That beat is stored; tready drops next cycle.
//       - WRAP_MODE=1 -> wr_addr wraps to 0. overflow is set on the first write beyond DEPTH.
//     - Final tlast beat on exactly the DEPTH-th word -> DONE, not ERR.
//   - DONE: rxdone=1, tready=0; hold until start or reset.
//   - ERR: rxdone=0, tready=0; hold until start or reset.
//  Port B
//   - enb&!web: doutb <= RAM[addrb], 1-cycle latency; doutb holds when enb=0.
//   - enb&web: RAM[addrb] <= dinb; doutb returns old data (read-first).
//   - Same-cycle stream write and port-B write to the same address: stream write wins.
//   - Same-cycle port-B read of the address being stream-written returns old data.
//  rxram_counter and rxdone update in the same cycle as the triggering beat (visible next edge).
// TESTING
//  1. niter=2, two 4-beat packets (tlast on beat 4 and 8), data 0x100..0x107
//     -> rxdone=1 after beat 8; rxram_counter=8; addrb=5 reads 0x105 one cycle later.
//  2. WRAP_MODE=0, ADDR_WIDTH=3, niter=1, 10 beats without tlast
//     -> state=ERR after the 8th beat; tready=0; rxram_counter=8; beats 9-10 not accepted.
//  3. WRAP_MODE=1, ADDR_WIDTH=3, niter=1, 10 beats with tlast on beat 10
//     -> DONE; overflow=1; RAM[0]=beat 9, RAM[1]=beat 10; rxram_counter=8.
//  4. start with niter=0 -> DONE next cycle; tready never asserted; rxram_counter=0.
//  5. slave_rst pulsed after 3 beats of a niter=1 capture
//     -> next cycle state=IDLE, counter=0, tready=0, rxdone=0; a fresh start captures normally.
//  6. Stream write and port-B write to addr 2 in the same cycle
//     -> RAM[2]=stream data; random tvalid gaps still yield exact beat count.

Source files
------------

// File: rtl/dlbf_slave_rxbuf_if.sv
// AXI-Stream beat channel into the DLBF slave receive buffer.
// The master drives data/valid/last; the slave (buffer) drives ready.
interface dlbf_slave_rxbuf_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/dlbf_slave_rxbuf.sv
// DLBF slave receive buffer: captures NITER tlast-delimited stream iterations into a RAM,
// reports progress, and exposes a read-first BRAM-style port B for readback and host writes.
module dlbf_slave_rxbuf #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 13,
   parameter int NITER_WIDTH = 12,
   parameter int WRAP_MODE   = 0
) (
   input  logic                   s_axis_clk,
   input  logic                   slave_rst,
   input  logic                   start,
   input  logic [NITER_WIDTH-1:0] niter,
   dlbf_slave_rxbuf_if.slave      s_axis,
   input  logic [ADDR_WIDTH-1:0]  addrb,
   input  logic [DATA_WIDTH-1:0]  dinb,
   input  logic                   enb,
   input  logic                   web,
   output logic [DATA_WIDTH-1:0]  doutb,
   output logic                   rxdone,
   output logic [3:0]             current_state,
   output logic [ADDR_WIDTH:0]    rxram_counter,
   output logic                   overflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_RECV = 4'd1;
   localparam logic [3:0] ST_DONE = 4'd2;
   localparam logic [3:0] ST_ERR  = 4'd3;

   localparam logic [ADDR_WIDTH:0]    DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]    CNT_ONE   = 1;
   localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = 1;
   localparam logic [NITER_WIDTH-1:0] ITER_ONE  = 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [3:0]             state_q,    state_d;
   logic                   tready_q,   tready_d;
   logic                   rxdone_q,   rxdone_d;
   logic                   overflow_q, overflow_d;
   logic [ADDR_WIDTH:0]    cnt_q,      cnt_d;
   logic [ADDR_WIDTH-1:0]  wr_addr_q,  wr_addr_d;
   logic [NITER_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
   logic [NITER_WIDTH-1:0] niter_q,    niter_d;
   logic [DATA_WIDTH-1:0]  doutb_q,    doutb_d;

   logic                   beat;
   logic                   last_beat;
   logic [NITER_WIDTH-1:0] iter_next;
   logic                   stream_we;
   logic                   portb_we;

   // tready_q only ever rises while in RECV, so a handshake implies a capture beat.
   assign beat      = s_axis.tvalid & tready_q;
   assign iter_next = iter_cnt_q + ITER_ONE;
   assign last_beat = beat & s_axis.tlast & (iter_next == niter_q);
   assign stream_we = beat & ~slave_rst;
   assign portb_we  = enb & web & ~slave_rst;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d    = state_q;
      niter_d    = niter_q;
      wr_addr_d  = wr_addr_q;
      iter_cnt_d = iter_cnt_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      doutb_d    = doutb_q;

      // Read-first: the flop captures the word as it was before this edge's writes.
      if (enb) begin
         doutb_d = mem[addrb];
      end

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               niter_d    = niter;
               wr_addr_d  = '0;
               iter_cnt_d = '0;
               cnt_d      = '0;
               overflow_d = 1'b0;
               state_d    = (niter == '0) ? ST_DONE : ST_RECV;
            end
         end
         ST_RECV: begin
            if (beat) begin
               wr_addr_d = wr_addr_q + ADDR_ONE;
               if (cnt_q != DEPTH_CNT) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else if (WRAP_MODE != 0) begin
                  overflow_d = 1'b1;
               end
               if (s_axis.tlast) begin
                  iter_cnt_d = iter_next;
               end
               // Finishing on exactly the DEPTH-th word is a clean completion, not an error.
               if (last_beat) begin
                  state_d = ST_DONE;
               end else if (WRAP_MODE == 0 && cnt_q == DEPTH_CNT - CNT_ONE) begin
                  state_d = ST_ERR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      tready_d = (state_d == ST_RECV);
      rxdone_d = (state_d == ST_DONE);
   end

   always_ff @(posedge s_axis_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (slave_rst) begin
         state_q    <= ST_IDLE;
         tready_q   <= 1'b0;
         rxdone_q   <= 1'b0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
         wr_addr_q  <= '0;
         iter_cnt_q <= '0;
         niter_q    <= '0;
         doutb_q    <= '0;
      end else begin
         state_q    <= state_d;
         tready_q   <= tready_d;
         rxdone_q   <= rxdone_d;
         overflow_q <= overflow_d;
         cnt_q      <= cnt_d;
         wr_addr_q  <= wr_addr_d;
         iter_cnt_q <= iter_cnt_d;
         niter_q    <= niter_d;
         doutb_q    <= doutb_d;
      end
   end

   // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive slave_rst.
   always_ff @(posedge s_axis_clk) begin
      if (portb_we) begin
         mem[addrb] <= dinb;
      end
      // Later assignment wins, so a colliding stream write takes priority over port B.
      if (stream_we) begin
         mem[wr_addr_q] <= s_axis.tdata;
      end
   end

   assign s_axis.tready  = tready_q;
   assign doutb          = doutb_q;
   assign rxdone         = rxdone_q;
   assign current_state  = state_q;
   assign rxram_counter  = cnt_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_dlbf_slave_rxbuf.sv
// Bench for dlbf_slave_rxbuf: a stop-on-full and a wrap-mode instance share one stimulus stream
// and are compared every cycle against a beat-count/queue reference model, plus directed corners.
module tb_dlbf_slave_rxbuf;
   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int NW    = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, tvalid, tlast, enb, web;
   logic [NW-1:0] niter;
   logic [DW-1:0] tdata, dinb;
   logic [AW-1:0] addrb;

   dlbf_slave_rxbuf_if #(.DATA_WIDTH(DW)) if_stop ();
   dlbf_slave_rxbuf_if #(.DATA_WIDTH(DW)) if_wrap ();

   assign if_stop.tdata  = tdata;
   assign if_stop.tvalid = tvalid;
   assign if_stop.tlast  = tlast;
   assign if_wrap.tdata  = tdata;
   assign if_wrap.tvalid = tvalid;
   assign if_wrap.tlast  = tlast;

   logic          d_tready [2];
   logic [DW-1:0] d_dout   [2];
   logic          d_done   [2];
   logic [3:0]    d_state  [2];
   logic [AW:0]   d_cnt    [2];
   logic          d_ovf    [2];

   assign d_tready[0] = if_stop.tready;
   assign d_tready[1] = if_wrap.tready;

   dlbf_slave_rxbuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NITER_WIDTH(NW), .WRAP_MODE(0)) u_stop (
      .s_axis_clk(clk), .slave_rst(rst), .start(start), .niter(niter), .s_axis(if_stop),
      .addrb(addrb), .dinb(dinb), .enb(enb), .web(web), .doutb(d_dout[0]), .rxdone(d_done[0]),
      .current_state(d_state[0]), .rxram_counter(d_cnt[0]), .overflow(d_ovf[0]));

   dlbf_slave_rxbuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NITER_WIDTH(NW), .WRAP_MODE(1)) u_wrap (
      .s_axis_clk(clk), .slave_rst(rst), .start(start), .niter(niter), .s_axis(if_wrap),
      .addrb(addrb), .dinb(dinb), .enb(enb), .web(web), .doutb(d_dout[1]), .rxdone(d_done[1]),
      .current_state(d_state[1]), .rxram_counter(d_cnt[1]), .overflow(d_ovf[1]));

   int n_pass = 0;
   int n_total = 0;
   int n_acc [2] = '{0, 0};
   string nm [2] = '{"stop", "wrap"};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: phase uses the published state codes, beat k of a capture lands at k mod DEPTH.
   int            m_phase  [2];
   int            m_stored [2];
   int            m_iters  [2];
   int            m_niter  [2];
   bit            m_ready  [2];
   bit            m_ovf    [2];
   logic [DW-1:0] m_dout   [2];
   logic [DW-1:0] m_mem    [2][DEPTH];

   task automatic model_step(input int m);
      bit acc;
      if (rst) begin
         m_phase[m] = 0; m_stored[m] = 0; m_iters[m] = 0; m_niter[m] = 0;
         m_ready[m] = 1'b0; m_ovf[m] = 1'b0; m_dout[m] = '0;
         return;
      end
      acc = tvalid && m_ready[m];
      if (enb) begin
         m_dout[m] = m_mem[m][addrb];
         if (web) m_mem[m][addrb] = dinb;
      end
      if (acc) begin
         if (m == 1 && m_stored[m] >= DEPTH) m_ovf[m] = 1'b1;
         m_mem[m][m_stored[m] % DEPTH] = tdata;
         m_stored[m]++;
         if (tlast) m_iters[m]++;
         if (tlast && m_iters[m] == m_niter[m]) m_phase[m] = 2;
         else if (m == 0 && m_stored[m] == DEPTH) m_phase[m] = 3;
      end else if (m_phase[m] != 1 && start) begin
         m_niter[m] = int'(niter);
         m_stored[m] = 0; m_iters[m] = 0; m_ovf[m] = 1'b0;
         m_phase[m] = (niter == 0) ? 2 : 1;
      end
      m_ready[m] = (m_phase[m] == 1);
   endtask

   task automatic compare_model();
      for (int m = 0; m < 2; m++) begin
         check({nm[m], ".state"},  32'(d_state[m]),  32'(m_phase[m]));
         check({nm[m], ".tready"}, 32'(d_tready[m]), 32'(m_ready[m]));
         check({nm[m], ".rxdone"}, 32'(d_done[m]),   32'(m_phase[m] == 2));
         check({nm[m], ".count"},  32'(d_cnt[m]),    32'((m_stored[m] > DEPTH) ? DEPTH : m_stored[m]));
         check({nm[m], ".ovf"},    32'(d_ovf[m]),    32'(m_ovf[m]));
         check({nm[m], ".doutb"},  32'(d_dout[m]),   32'(m_dout[m]));
      end
   endtask

   // One clock: inputs are already stable; model advances at the edge, outputs sampled at negedge.
   task automatic cycle();
      for (int m = 0; m < 2; m++)
         if (!rst && tvalid && d_tready[m]) n_acc[m]++;
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      compare_model();
   endtask

   task automatic set_idle();
      start = 1'b0; niter = '0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
      enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
   endtask

   typedef struct {
      bit            start;
      logic [NW-1:0] niter;
      bit            tvalid;
      bit            tlast;
      logic [DW-1:0] tdata;
      bit            enb;
      logic [AW-1:0] addrb;
      bit            chk_dout;
      logic [DW-1:0] exp_dout;
      logic [3:0]    exp_state;
      bit            exp_tready;
      logic [AW:0]   exp_cnt;
      bit            exp_rxdone;
   } vec_t;

   function automatic vec_t mk(input bit st, input int ni, input bit tv, input bit tl, input int td,
                               input bit en, input int ab, input bit cd, input int ed,
                               input int es, input bit et, input int ec, input bit ex);
      vec_t v;
      v.start = st; v.niter = NW'(ni); v.tvalid = tv; v.tlast = tl; v.tdata = DW'(td);
      v.enb = en; v.addrb = AW'(ab); v.chk_dout = cd; v.exp_dout = DW'(ed);
      v.exp_state = 4'(es); v.exp_tready = et; v.exp_cnt = (AW+1)'(ec); v.exp_rxdone = ex;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      int idx, budget, acc0, acc1;

      // Two 4-beat packets (niter=2) filling exactly DEPTH words, readback, then niter=0 start.
      vecs.push_back(mk(1, 2, 0, 0, 0,     0, 0, 0, 0,     1, 1, 0, 0));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 0, 1, (i == 3 || i == 7), 'h100 + i, 0, 0, 0, 0,
                           (i == 7) ? 2 : 1, (i != 7), i + 1, (i == 7)));
      vecs.push_back(mk(0, 0, 0, 0, 0,     1, 5, 1, 'h105, 2, 0, 8, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0,     0, 0, 0, 0,     2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 'h1ff, 0, 0, 0, 0,     2, 0, 0, 1));

      set_idle();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;

      // Give every RAM word a known value before anything reads it.
      for (int i = 0; i < DEPTH; i++) begin
         set_idle();
         enb = 1'b1; web = 1'b1; addrb = AW'(i); dinb = DW'(32'hA000 + i);
         cycle();
      end

      foreach (vecs[r]) begin
         set_idle();
         start = vecs[r].start; niter = vecs[r].niter; tvalid = vecs[r].tvalid;
         tlast = vecs[r].tlast; tdata = vecs[r].tdata; enb = vecs[r].enb; addrb = vecs[r].addrb;
         cycle();
         check($sformatf("vec%0d.state", r),  32'(d_state[0]),  32'(vecs[r].exp_state));
         check($sformatf("vec%0d.tready", r), 32'(d_tready[0]), 32'(vecs[r].exp_tready));
         check($sformatf("vec%0d.count", r),  32'(d_cnt[0]),    32'(vecs[r].exp_cnt));
         check($sformatf("vec%0d.rxdone", r), 32'(d_done[0]),   32'(vecs[r].exp_rxdone));
         if (vecs[r].chk_dout)
            check($sformatf("vec%0d.doutb", r), 32'(d_dout[0]), 32'(vecs[r].exp_dout));
      end

      // Ten beats, tlast only on the tenth: stop instance errors at 8, wrap instance completes.
      set_idle();
      start = 1'b1; niter = 4'd1;
      cycle();
      acc0 = n_acc[0]; acc1 = n_acc[1];
      for (int k = 0; k < 10; k++) begin
         set_idle();
         tvalid = 1'b1; tdata = DW'(32'h200 + k); tlast = (k == 9);
         cycle();
         if (k == 7) check("full.stop_err_at_8", 32'(d_state[0]), 32'd3);
      end
      check("full.stop_state",  32'(d_state[0]),       32'd3);
      check("full.stop_tready", 32'(d_tready[0]),      32'd0);
      check("full.stop_count",  32'(d_cnt[0]),         32'd8);
      check("full.stop_beats",  32'(n_acc[0] - acc0),  32'd8);
      check("full.wrap_state",  32'(d_state[1]),       32'd2);
      check("full.wrap_ovf",    32'(d_ovf[1]),         32'd1);
      check("full.wrap_count",  32'(d_cnt[1]),         32'd8);
      check("full.wrap_beats",  32'(n_acc[1] - acc1),  32'd10);
      set_idle(); enb = 1'b1; addrb = 3'd0;
      cycle();
      check("full.wrap_ram0", 32'(d_dout[1]), 32'h208);
      check("full.stop_ram0", 32'(d_dout[0]), 32'h200);
      set_idle(); enb = 1'b1; addrb = 3'd1;
      cycle();
      check("full.wrap_ram1", 32'(d_dout[1]), 32'h209);

      // niter=0 from ERR/DONE: straight to DONE, counters and overflow cleared, tready stays low.
      set_idle();
      start = 1'b1; niter = 4'd0;
      cycle();
      check("zero.stop_state", 32'(d_state[0]), 32'd2);
      check("zero.stop_count", 32'(d_cnt[0]),   32'd0);
      check("zero.wrap_ovf",   32'(d_ovf[1]),   32'd0);
      for (int k = 0; k < 3; k++) begin
         set_idle(); tvalid = 1'b1;
         cycle();
         check("zero.tready", 32'(d_tready[0] | d_tready[1]), 32'd0);
      end

      // Reset three beats into a capture, then a clean capture afterwards.
      set_idle(); start = 1'b1; niter = 4'd1;
      cycle();
      for (int k = 0; k < 3; k++) begin
         set_idle(); tvalid = 1'b1; tdata = DW'(32'h300 + k);
         cycle();
      end
      set_idle(); rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("rst.state",  32'(d_state[0]),  32'd0);
      check("rst.count",  32'(d_cnt[0]),    32'd0);
      check("rst.tready", 32'(d_tready[0]), 32'd0);
      check("rst.rxdone", 32'(d_done[0]),   32'd0);
      set_idle(); start = 1'b1; niter = 4'd1;
      cycle();
      for (int k = 0; k < 2; k++) begin
         set_idle(); tvalid = 1'b1; tdata = DW'(32'h310 + k); tlast = (k == 1);
         cycle();
      end
      check("rst.recap_state", 32'(d_state[0]), 32'd2);
      check("rst.recap_count", 32'(d_cnt[0]),   32'd2);
      set_idle(); enb = 1'b1; addrb = 3'd2;
      cycle();
      check("rst.ram_kept", 32'(d_dout[0]), 32'h302);

      // Five beats with random gaps; beat 2 collides with a port-B write, beat 3 with a read.
      set_idle(); start = 1'b1; niter = 4'd1;
      cycle();
      idx = 0; budget = 0; acc0 = n_acc[0];
      while (idx < 5 && budget < 100) begin
         set_idle();
         tvalid = 1'($urandom_range(0, 1));
         tdata = DW'(32'h400 + idx); tlast = (idx == 4);
         if (tvalid && idx == 2) begin
            enb = 1'b1; web = 1'b1; addrb = 3'd2; dinb = 16'hBEEF;
         end else if (tvalid && idx == 3) begin
            enb = 1'b1; addrb = 3'd3;
         end
         cycle();
         if (tvalid && idx == 3) check("coll.read_old", 32'(d_dout[0]), 32'h203);
         if (tvalid) idx++;
         budget++;
      end
      check("coll.in_budget", 32'(idx),              32'd5);
      check("coll.beats",     32'(n_acc[0] - acc0),  32'd5);
      check("coll.count",     32'(d_cnt[0]),         32'd5);
      check("coll.state",     32'(d_state[0]),       32'd2);
      set_idle(); enb = 1'b1; addrb = 3'd2;
      cycle();
      check("coll.stream_wins", 32'(d_dout[0]), 32'h402);

      // Randomised traffic checked against the reference model every cycle.
      for (int c = 0; c < 3000; c++) begin
         set_idle();
         rst    = ($urandom_range(0, 299) == 0);
         start  = ($urandom_range(0, 19) == 0);
         niter  = NW'($urandom_range(0, 3));
         tvalid = ($urandom_range(0, 9) < 6);
         tlast  = ($urandom_range(0, 3) == 0);
         tdata  = DW'($urandom);
         enb    = ($urandom_range(0, 9) < 4);
         web    = 1'($urandom_range(0, 1));
         addrb  = AW'($urandom_range(0, DEPTH - 1));
         dinb   = DW'($urandom);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
